// File: rtl/dice_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dice_pkg
//  Description : Shared die indices, sides lookup and sequencer state enum.
//  Revision    : 1.0 - initial release
// ============================================================================
package dice_pkg;

    localparam int NUM_DICE = 7;

    localparam logic [2:0] DIE_D4   = 3'd0;
    localparam logic [2:0] DIE_D6   = 3'd1;
    localparam logic [2:0] DIE_D8   = 3'd2;
    localparam logic [2:0] DIE_D10  = 3'd3;
    localparam logic [2:0] DIE_D12  = 3'd4;
    localparam logic [2:0] DIE_D20  = 3'd5;
    localparam logic [2:0] DIE_D100 = 3'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SPIN = 2'd1,
        SLOW = 2'd2,
        SHOW = 2'd3
    } state_t;

    // Two-digit BCD side count; 100 is folded onto 00.
    function automatic logic [7:0] sides_bcd(input logic [2:0] idx);
        logic [7:0] v;
        case (idx)
            DIE_D4:   v = 8'h04;
            DIE_D6:   v = 8'h06;
            DIE_D8:   v = 8'h08;
            DIE_D10:  v = 8'h10;
            DIE_D12:  v = 8'h12;
            DIE_D20:  v = 8'h20;
            DIE_D100: v = 8'h00;
            default:  v = 8'h06;
        endcase
        return v;
    endfunction

endpackage : dice_pkg
`default_nettype wire

// File: rtl/bcd_mod_down_counter.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_mod_down_counter
//  Description : Two-digit BCD down-counter wrapping from 01 back to load_val.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_mod_down_counter #(
    parameter logic [7:0] RESET_VAL = 8'h06
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       en,
    output logic [7:0] value
);

    logic [7:0] r_value;
    logic [7:0] w_dec;

    // 00 stands for 100, so it steps to 99 rather than underflowing.
    always_comb begin
        w_dec = r_value;
        if (r_value == 8'h01) begin
            w_dec = load_val;
        end else if (r_value == 8'h00) begin
            w_dec = 8'h99;
        end else if (r_value[3:0] == 4'd0) begin
            w_dec = {r_value[7:4] - 4'd1, 4'd9};
        end else begin
            w_dec = {r_value[7:4], r_value[3:0] - 4'd1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= RESET_VAL;
        end else if (load) begin
            r_value <= load_val;
        end else if (en) begin
            r_value <= w_dec;
        end
    end

    assign value = r_value;

endmodule : bcd_mod_down_counter
`default_nettype wire

// File: rtl/dice_roll_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : dice_roll_sequencer
//  Description : IDLE/SPIN/SLOW/SHOW dice roll controller with BCD display.
//  Revision    : 1.0 - initial release
// ============================================================================
module dice_roll_sequencer
    import dice_pkg::*;
#(
    parameter int SLOW_STEPS = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic [6:0] btn_die,
    output logic [3:0] digit10,
    output logic [3:0] digit1,
    output logic       rolling,
    output logic [2:0] die_idx
);

    localparam logic [3:0] c_last_step = 4'(SLOW_STEPS);

    state_t     r_state, w_state_next;
    logic [6:0] r_btn_cur, r_btn_prev;
    logic [6:0] w_press;
    logic [2:0] r_die_idx, w_die_idx_next, w_new_idx;
    logic [7:0] r_disp, w_disp_next;
    logic [3:0] r_step_k, w_step_k_next;
    logic [3:0] r_wait_w, w_wait_w_next;
    logic [3:0] w_wait_inc;
    logic       w_cnt_load;
    logic       w_cnt_en;
    logic [7:0] w_cnt_load_val;
    logic [7:0] w_cnt_value;

    // Buttons are registered once before edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btn_cur  <= '0;
            r_btn_prev <= '0;
        end else begin
            r_btn_cur  <= btn_die;
            r_btn_prev <= r_btn_cur;
        end
    end

    assign w_press = r_btn_cur & ~r_btn_prev;

    always_comb begin
        w_new_idx = DIE_D4;
        for (int i = NUM_DICE - 1; i >= 0; i--) begin
            if (w_press[i]) begin
                w_new_idx = 3'(i);
            end
        end
    end

    assign w_wait_inc     = r_wait_w + 4'd1;
    assign w_cnt_en       = (r_state == SPIN) || (r_state == SLOW);
    assign w_cnt_load_val = w_cnt_load ? sides_bcd(w_new_idx) : sides_bcd(r_die_idx);

    bcd_mod_down_counter #(
        .RESET_VAL (8'h06)
    ) u_roll_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_cnt_load),
        .load_val (w_cnt_load_val),
        .en       (w_cnt_en),
        .value    (w_cnt_value)
    );

    always_comb begin
        w_state_next   = r_state;
        w_die_idx_next = r_die_idx;
        w_disp_next    = r_disp;
        w_step_k_next  = r_step_k;
        w_wait_w_next  = r_wait_w;
        w_cnt_load     = 1'b0;
        case (r_state)
            IDLE, SHOW: begin
                // A roll start swallows any tick arriving in the same cycle.
                if (|w_press) begin
                    w_state_next   = SPIN;
                    w_die_idx_next = w_new_idx;
                    w_cnt_load     = 1'b1;
                    w_step_k_next  = 4'd1;
                    w_wait_w_next  = 4'd0;
                end
            end
            SPIN: begin
                if (tick) begin
                    w_disp_next = w_cnt_value;
                end
                if (!r_btn_cur[r_die_idx]) begin
                    w_state_next = SLOW;
                end
            end
            SLOW: begin
                if (tick) begin
                    if (w_wait_inc == r_step_k) begin
                        w_disp_next   = w_cnt_value;
                        w_wait_w_next = 4'd0;
                        if (r_step_k == c_last_step) begin
                            w_state_next = SHOW;
                        end else begin
                            w_step_k_next = r_step_k + 4'd1;
                        end
                    end else begin
                        w_wait_w_next = w_wait_inc;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_die_idx <= DIE_D6;
            r_disp    <= 8'h01;
            r_step_k  <= 4'd1;
            r_wait_w  <= 4'd0;
        end else begin
            r_state   <= w_state_next;
            r_die_idx <= w_die_idx_next;
            r_disp    <= w_disp_next;
            r_step_k  <= w_step_k_next;
            r_wait_w  <= w_wait_w_next;
        end
    end

    assign digit10 = r_disp[7:4];
    assign digit1  = r_disp[3:0];
    assign rolling = (r_state == SPIN) || (r_state == SLOW);
    assign die_idx = r_die_idx;

endmodule : dice_roll_sequencer
`default_nettype wire

// File: tb/tb_dice_roll_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dice_roll_sequencer
//  Description : Self-checking bench with a behavioural dice roll model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dice_roll_sequencer;

    localparam int SLOW_N = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic [6:0] btn_die = '0;
    logic [3:0] digit10, digit1;
    logic       rolling;
    logic [2:0] die_idx;

    int checks = 0;
    int passed = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    dice_roll_sequencer #(
        .SLOW_STEPS (SLOW_N)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick    (tick),
        .btn_die (btn_die),
        .digit10 (digit10),
        .digit1  (digit1),
        .rolling (rolling),
        .die_idx (die_idx)
    );

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    endtask

    // Behavioural model: die value as an integer 1..sides, SLOW loads fall on
    // triangular tick counts since release.
    int         sides_tab [7] = '{4, 6, 8, 10, 12, 20, 100};
    logic [6:0] m_seen_now, m_seen_before, m_press;
    int         m_phase;        // 0 idle, 1 spin, 2 slow, 3 show
    int         m_idx, m_sides, m_cnt, m_old_cnt, m_disp, m_slow_ticks, m_loads;

    function automatic bit is_tri(input int t);
        for (int k = 1; k <= SLOW_N; k++)
            if (t == k * (k + 1) / 2) return 1'b1;
        return 1'b0;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_phase = 0; m_idx = 1; m_sides = 6; m_cnt = 6; m_disp = 1;
                m_seen_now = '0; m_seen_before = '0; m_slow_ticks = 0; m_loads = 0;
            end else begin
                m_press   = m_seen_now & ~m_seen_before;
                m_old_cnt = m_cnt;
                if (m_phase == 0 || m_phase == 3) begin
                    if (m_press != 0) begin
                        for (int i = 6; i >= 0; i--) if (m_press[i]) m_idx = i;
                        m_sides = sides_tab[m_idx];
                        m_cnt = m_sides; m_phase = 1; m_slow_ticks = 0; m_loads = 0;
                    end
                end else begin
                    if (m_phase == 1) begin
                        if (tick) begin m_disp = m_old_cnt; m_loads++; end
                        if (!m_seen_now[m_idx]) m_phase = 2;
                    end else if (tick) begin
                        m_slow_ticks++;
                        if (is_tri(m_slow_ticks)) begin m_disp = m_old_cnt; m_loads++; end
                        if (m_slow_ticks == SLOW_N * (SLOW_N + 1) / 2) m_phase = 3;
                    end
                    m_cnt = (m_old_cnt == 1) ? m_sides : m_old_cnt - 1;
                end
                m_seen_before = m_seen_now;
                m_seen_now    = btn_die;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                check("digit10", int'(digit10), (m_disp == 100) ? 0 : m_disp / 10);
                check("digit1", int'(digit1), (m_disp == 100) ? 0 : m_disp % 10);
                check("rolling", int'(rolling), int'(m_phase == 1 || m_phase == 2));
                check("die_idx", int'(die_idx), m_idx);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) step();
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    // Ticks every 8 cycles until the roll ends; returns ticks seen while rolling.
    task automatic run_to_show(output int rolled);
        int guard = 0;
        rolled = 0;
        while (rolling && guard < 40) begin
            idle_cycles(7);
            if (rolling) rolled++;
            pulse_tick();
            guard++;
        end
        check("show_timeout", int'(rolling), 0);
    endtask

    task automatic start_roll(input logic [6:0] b);
        btn_die = b;
        step();
        step();
    endtask

    int n_rolled, n_spin;

    initial begin
        #12;
        rst_n = 1'b1;
        step();
        cmp_en = 1'b1;
        check("rst_digit10", int'(digit10), 0);
        check("rst_digit1", int'(digit1), 1);
        check("rst_rolling", int'(rolling), 0);
        check("rst_die_idx", int'(die_idx), 1);

        repeat (100) begin idle_cycles(3); pulse_tick(); end
        check("idle_digit1", int'(digit1), 1);
        check("idle_rolling", int'(rolling), 0);

        // D6 held for 3 ticks, then released
        start_roll(7'b0000010);
        check("d6_rolling", int'(rolling), 1);
        n_spin = 0;
        repeat (3) begin idle_cycles(7); if (rolling) n_spin++; pulse_tick(); end
        btn_die = '0;
        idle_cycles(3);
        run_to_show(n_rolled);
        check("d6_roll_ticks", n_spin + n_rolled, 9);
        check("d6_loads", m_loads, 6);
        check("d6_tens", int'(digit10), 0);
        check("d6_range", int'(digit1 >= 4'd1 && digit1 <= 4'd6), 1);
        repeat (5) begin idle_cycles(5); pulse_tick(); end
        check("d6_show_hold", int'(rolling), 0);

        // D4 and D20 in the same cycle
        start_roll(7'b0100001);
        check("d4d20_idx", int'(die_idx), 0);
        repeat (2) begin idle_cycles(7); pulse_tick(); end
        btn_die = '0;
        idle_cycles(3);
        run_to_show(n_rolled);
        check("d4_tens", int'(digit10), 0);
        check("d4_range", int'(digit1 >= 4'd1 && digit1 <= 4'd4), 1);

        // D12 pressed during SLOW of a D8 roll is ignored
        start_roll(7'b0000100);
        repeat (2) begin idle_cycles(7); pulse_tick(); end
        btn_die = '0;
        idle_cycles(3);
        pulse_tick();
        btn_die = 7'b0010000;
        run_to_show(n_rolled);
        check("d8_keep_idx", int'(die_idx), 2);
        btn_die = '0;
        idle_cycles(3);
        // D12 in SHOW with a coincident tick: roll starts, tick dropped
        btn_die = 7'b0010000;
        step();
        tick = 1'b1;
        step();
        tick = 1'b0;
        check("d12_idx", int'(die_idx), 4);
        check("d12_rolling", int'(rolling), 1);
        btn_die = '0;
        idle_cycles(3);
        run_to_show(n_rolled);

        // D100: value 01 after 99 decrements, wraps to 00 on the next
        start_roll(7'b1000000);
        idle_cycles(99);
        tick = 1'b1;
        step();
        check("d100_at01_tens", int'(digit10), 0);
        check("d100_at01_units", int'(digit1), 1);
        step();
        tick = 1'b0;
        check("d100_wrap_tens", int'(digit10), 0);
        check("d100_wrap_units", int'(digit1), 0);
        btn_die = '0;
        idle_cycles(3);
        run_to_show(n_rolled);

        // Reset mid-SPIN with D10 held through deassertion
        start_roll(7'b0001000);
        idle_cycles(2);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_digit10", int'(digit10), 0);
        check("async_rst_digit1", int'(digit1), 1);
        check("async_rst_rolling", int'(rolling), 0);
        check("async_rst_idx", int'(die_idx), 1);
        idle_cycles(2);
        #2;
        rst_n = 1'b1;
        step();
        check("held_first_edge", int'(rolling), 0);
        step();
        check("held_spin", int'(rolling), 1);
        check("held_idx", int'(die_idx), 3);
        btn_die = '0;
        idle_cycles(3);
        run_to_show(n_rolled);

        idle_cycles(2);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule : tb_dice_roll_sequencer
`default_nettype wire

// File: doc/dice_roll_sequencer.md
# dice_roll_sequencer

Controller that sequences a dice roll on the two-digit BCD display datapath. It sits between the debounced die buttons and the 7-segment encoder/multiplexer, and owns the die-selection state machine and the decelerating "spin" animation. It also owns the modulo-N BCD roll counter whose value is finally latched as the result. It replaces ad-hoc decrement-on-press logic with a deterministic IDLE → SPIN → SLOW → SHOW sequence paced by the 32 Hz prescaler tick.

## Interface
Parameters:
- SLOW_STEPS, 6, number of decelerating display updates after release; legal range 1..15.

Ports:
- clk  in  1  system clock (32768 Hz)
- rst_n  in  1  reset; asynchronous, active-low
- tick  in  1  one-cycle pulse at 32 Hz from the prescaler
- btn_die  in  7  debounced button levels, active high; index 0..6 = D4, D6, D8, D10, D12, D20, D100
- digit10  out  4  BCD tens digit to display
- digit1  out  4  BCD units digit to display
- rolling  out  1  high in SPIN and SLOW; display may flash or dim
- die_idx  out  3  index of the currently selected die

## Operation
- Rising-edge detect on btn_die uses one register stage of previous levels. A new press is any bit with cur & ~prev.
- Sides table, BCD: 04, 06, 08, 10, 12, 20, 100. D100 result 100 is shown as digits 0,0 (percentile convention).
- Roll counter:
  - Two-digit BCD down-counter; range 1..sides, with 100 encoded as 00.
  - Decrements every clk in SPIN and SLOW.
  - 01 wraps to sides.
  - Reloaded to sides on roll start.
- States:
  - IDLE: reset state, no die chosen. A new press → SPIN.
  - SPIN: entered while the starting button is held. On every tick, the display is loaded from the counter. Starting button low → SLOW. Other buttons are ignored.
  - SLOW:
    - Step k runs from 1 to SLOW_STEPS, with a wait counter w.
    - On each tick, w increments. When w reaches k, the display is loaded from the counter, w clears, and k increments.
    - After the load at k = SLOW_STEPS → SHOW.
    - All presses are ignored.
  - SHOW: result held, counter frozen. A new press → SPIN with the new die.
- Roll start (IDLE/SHOW plus a new press):
  - die_idx latches the lowest set index among the new-press bits.
  - Counter reloads to that die's sides.
  - k = 1, w = 0.
- Only the button that started the roll is monitored for release.

## Timing
- Reset values (async, immediate): state IDLE, digit10 = 0, digit1 = 1, rolling = 0, die_idx = 1 (D6), counter = 06, edge-detect registers = 0.
- Press edge sampled at edge N: state SPIN, rolling = 1 and counter reload all visible after edge N+1.
- Display loads happen on the same edge that consumes tick; digits change one cycle after the tick cycle.
- Release is seen one cycle after btn_die drops. SLOW lasts exactly SLOW_STEPS·(SLOW_STEPS+1)/2 ticks, i.e. 21 ticks (about 0.66 s) at default.
- rolling falls on the same edge as the final display load.
- Simultaneous events:
  - A new press and a tick in the same cycle while in IDLE/SHOW: the roll start wins and the tick is dropped.
  - Release and a tick in the same cycle while in SPIN: the display loads, then the state becomes SLOW.
- Press and release within one cycle between ticks: the roll is still valid. SPIN lasts ≥1 cycle, then SLOW.
- Reset asserted mid-roll: immediate return to reset values. After deassertion, no roll starts until a fresh rising edge.
- Button held across reset deassertion: the edge detector is 0 after reset, so the held level counts as a press one cycle after deassertion.

## Structure
- Shared package dice_pkg:
  - Die index localparams (DIE_D4..DIE_D100).
  - Sides BCD lookup function.
  - State enum (IDLE, SPIN, SLOW, SHOW).
- Sub-module bcd_mod_down_counter:
  - Inputs: clk, rst_n, load, load_val[7:0], en.
  - Output: value[7:0].
  - Wrap to load_val below 01; handles the 00 = 100 encoding.
- The top-level FSM, edge detect and slow-step counters live in dice_roll_sequencer.

## Test plan
- Reset with no buttons → digits 0,1; rolling = 0; die_idx = 1; no change over 100 ticks.
- Press D6 for 3 ticks, then release, SLOW_STEPS = 3 → rolling high for 3 + 6 ticks; exactly 3 + 3 display loads; final digits in 1..6; tens = 0; SHOW holds.
- D4 and D20 rise in the same cycle → die_idx = 0; every displayed value stays within 1..4.
- D100 with 0x64 cycles forced between reload and freeze → display 0,0. Separately, a counter at 01 wraps to 00 (100) on the next enable.
- Press D12 during SLOW of a D8 roll → ignored: die_idx stays 2, SLOW completes. A D12 press in SHOW starts a new roll, die_idx = 4.
- Assert rst_n mid-SPIN → digits 0,1 and IDLE immediately without waiting for clk. Button held through deassertion → SPIN one cycle after deassertion.
